// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite arbiter: FSM state encoding and response codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter: one-hot grant from req and the preferred-master pointer.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       rr_next
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = rr ? 2'b10 : 2'b01;
    end
    // Pointer moves to the other master whenever a grant is taken.
    rr_next = rr;
    if (advance && (grant != 2'b00)) begin
      rr_next = ~grant[1];
    end
  end

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter: one transaction at a time, round-robin,
// channels forwarded combinationally from the registered grant.
module axi_lite_arbiter_2to1
  import axi_lite_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic [1:0]      M_AWVALID,
  input  logic [2*AW-1:0] M_AWADDR,
  output logic [1:0]      M_AWREADY,
  input  logic [1:0]      M_WVALID,
  input  logic [2*DW-1:0] M_WDATA,
  output logic [1:0]      M_WREADY,
  output logic [1:0]      M_BVALID,
  output logic [3:0]      M_BRESP,
  input  logic [1:0]      M_BREADY,
  input  logic [1:0]      M_ARVALID,
  input  logic [2*AW-1:0] M_ARADDR,
  output logic [1:0]      M_ARREADY,
  output logic [1:0]      M_RVALID,
  output logic [2*DW-1:0] M_RDATA,
  output logic [3:0]      M_RRESP,
  input  logic [1:0]      M_RREADY,
  output logic            S_AWVALID,
  output logic [AW-1:0]   S_AWADDR,
  input  logic            S_AWREADY,
  output logic            S_WVALID,
  output logic [DW-1:0]   S_WDATA,
  input  logic            S_WREADY,
  input  logic            S_BVALID,
  input  logic [1:0]      S_BRESP,
  output logic            S_BREADY,
  output logic            S_ARVALID,
  output logic [AW-1:0]   S_ARADDR,
  input  logic            S_ARREADY,
  input  logic            S_RVALID,
  input  logic [DW-1:0]   S_RDATA,
  input  logic [1:0]      S_RRESP,
  output logic            S_RREADY,
  output logic            grant_id,
  output logic            busy
);

  state_t     state_q, state_d;
  logic       grant_id_q, grant_id_d;
  logic       rr_q, rr_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [1:0] req;
  logic [1:0] arb_grant;
  logic       rr_next;
  logic       in_wa, in_wr, in_ra, in_rd;
  logic       aw_hs, w_hs;

  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata;

  assign req = M_AWVALID | M_ARVALID;

  // The pointer is updated when the grant is taken rather than at completion; decisions
  // only happen in IDLE and reset clears it, so the arbitration order is identical.
  rr_arbiter_2 u_rr (
    .req     (req),
    .rr      (rr_q),
    .advance (state_q == IDLE),
    .grant   (arb_grant),
    .rr_next (rr_next)
  );

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

  assign in_wa = (state_q == WR_ADDR);
  assign in_wr = (state_q == WR_RESP);
  assign in_ra = (state_q == RD_ADDR);
  assign in_rd = (state_q == RD_DATA);

  assign m_awaddr = grant_id_q ? M_AWADDR[AW +: AW] : M_AWADDR[0 +: AW];
  assign m_araddr = grant_id_q ? M_ARADDR[AW +: AW] : M_ARADDR[0 +: AW];
  assign m_wdata  = grant_id_q ? M_WDATA[DW +: DW]  : M_WDATA[0 +: DW];

  // Slave side: only the active channel carries anything; completed channels are masked.
  assign S_AWVALID = in_wa && M_AWVALID[grant_id_q] && !aw_done_q;
  assign S_AWADDR  = in_wa ? m_awaddr : '0;
  assign S_WVALID  = in_wa && M_WVALID[grant_id_q] && !w_done_q;
  assign S_WDATA   = in_wa ? m_wdata : '0;
  assign S_BREADY  = in_wr && M_BREADY[grant_id_q];
  assign S_ARVALID = in_ra && M_ARVALID[grant_id_q];
  assign S_ARADDR  = in_ra ? m_araddr : '0;
  assign S_RREADY  = in_rd && M_RREADY[grant_id_q];

  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs  = S_WVALID && S_WREADY;

  for (genvar i = 0; i < 2; i++) begin : g_mst
    logic sel;
    assign sel = busy && (grant_id_q == 1'(i));
    assign M_AWREADY[i]           = sel && in_wa && S_AWREADY && !aw_done_q;
    assign M_WREADY[i]            = sel && in_wa && S_WREADY && !w_done_q;
    assign M_BVALID[i]            = sel && in_wr && S_BVALID;
    assign M_BRESP[2*i +: 2]      = (sel && in_wr) ? S_BRESP : 2'b00;
    assign M_ARREADY[i]           = sel && in_ra && S_ARREADY;
    assign M_RVALID[i]            = sel && in_rd && S_RVALID;
    assign M_RDATA[i*DW +: DW]    = (sel && in_rd) ? S_RDATA : '0;
    assign M_RRESP[2*i +: 2]      = (sel && in_rd) ? S_RRESP : 2'b00;
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    unique case (state_q)
      IDLE: begin
        rr_d = rr_next;
        if (arb_grant != 2'b00) begin
          grant_id_d = arb_grant[1];
          state_d    = M_AWVALID[arb_grant[1]] ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (S_BVALID && S_BREADY) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (S_ARVALID && S_ARREADY) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (S_RVALID && S_RREADY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      grant_id_q <= 1'b0;
      rr_q       <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_q       <= rr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule
